// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer feeding a Moore debounce FSM.
// out_S/busy decode from state; rise/fall are registered one-cycle pulses.
module debounce_sync #(
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out_S,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] N_C = CNT_W'(STABLE_CYCLES);

    logic             sync1_q, sync2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            if (RESET_LEVEL) state_q <= IDLE_HIGH;
            else             state_q <= IDLE_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            // cnt counts qualifying samples already seen; first one is taken on WAIT entry
            case (state_q)
                IDLE_LOW: begin
                    if (sync2_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == N_C) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2_q) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == N_C) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        out_S = 1'b0;
        busy  = 1'b0;
        case (state_q)
            WAIT_HIGH: busy = 1'b1;
            IDLE_HIGH: out_S = 1'b1;
            WAIT_LOW: begin
                out_S = 1'b1;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: N=4 main instance plus N=1, RESET_LEVEL=1
// and CNT_W=4/N=15 boundary instances sharing one clock.
module tb_debounce_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, in0, out0, rise0, fall0, busy0;
    logic rst1, in1, out1, rise1, fall1, busy1;
    logic rst2, in2, out2, rise2, fall2, busy2;
    logic rst3, in3, out3, rise3, fall3, busy3;

    debounce_sync #(.CNT_W(16), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) u0 (
        .clk(clk), .reset(rst0), .in(in0), .out_S(out0), .rise(rise0), .fall(fall0), .busy(busy0));
    debounce_sync #(.CNT_W(16), .STABLE_CYCLES(1), .RESET_LEVEL(1'b0)) u1 (
        .clk(clk), .reset(rst1), .in(in1), .out_S(out1), .rise(rise1), .fall(fall1), .busy(busy1));
    debounce_sync #(.CNT_W(16), .STABLE_CYCLES(4), .RESET_LEVEL(1'b1)) u2 (
        .clk(clk), .reset(rst2), .in(in2), .out_S(out2), .rise(rise2), .fall(fall2), .busy(busy2));
    debounce_sync #(.CNT_W(4), .STABLE_CYCLES(15), .RESET_LEVEL(1'b0)) u3 (
        .clk(clk), .reset(rst3), .in(in3), .out_S(out3), .rise(rise3), .fall(fall3), .busy(busy3));

    int nvec = 0;
    int nmis = 0;
    int nr [4];
    int nf [4];
    logic sawbusy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // advance one edge, sample 1ns later, tally pulses
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (rise0) nr[0]++;
            if (fall0) nf[0]++;
            if (rise1) nr[1]++;
            if (fall1) nf[1]++;
            if (rise2) nr[2]++;
            if (fall2) nf[2]++;
            if (rise3) nr[3]++;
            if (fall3) nf[3]++;
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 4; k++) begin
            nr[k] = 0;
            nf[k] = 0;
        end
    endtask

    initial begin
        clr();
        rst0 = 1'b1; in0 = 1'b0;
        rst1 = 1'b1; in1 = 1'b0;
        rst2 = 1'b1; in2 = 1'b1;
        rst3 = 1'b1; in3 = 1'b0;

        // 1: reset with in toggling, then quiet release
        for (int i = 0; i < 3; i++) begin
            in0 = i[0];
            tick();
            chk("rst_outs", {28'd0, out0, busy0, rise0, fall0}, 32'h0);
        end
        chk("rl1_rst_out", {31'd0, out2}, 32'h1);
        rst0 = 1'b0; in0 = 1'b0;
        clr();
        tick(20);
        chk("rel_rise", nr[0], 0);
        chk("rel_fall", nf[0], 0);
        chk("rel_out", {31'd0, out0}, 32'h0);

        // 2: clean step
        clr();
        in0 = 1'b1;
        tick(2);
        chk("step_busy_e1", {31'd0, busy0}, 32'h0);
        tick();
        chk("step_busy_e2", {30'd0, out0, busy0}, 32'h1);
        tick(3);
        chk("step_e5", {28'd0, out0, busy0, rise0, fall0}, 32'b0100);
        tick();
        chk("step_e6", {28'd0, out0, busy0, rise0, fall0}, 32'b1010);
        tick();
        chk("step_e7", {28'd0, out0, busy0, rise0, fall0}, 32'b1000);
        tick(5);
        chk("step_nrise", nr[0], 1);
        chk("step_nfall", nf[0], 0);
        in0 = 1'b0;
        tick(10);
        chk("step_back_fall", nf[0], 1);
        chk("step_back_out", {31'd0, out0}, 32'h0);

        // 3: 4-cycle glitch rejected, 5-cycle pulse accepted
        clr();
        sawbusy = 1'b0;
        in0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) in0 = 1'b0;
            tick();
            if (busy0) sawbusy = 1'b1;
        end
        chk("glitch_busy", {31'd0, sawbusy}, 32'h1);
        chk("glitch_out", {31'd0, out0}, 32'h0);
        chk("glitch_rise", nr[0], 0);
        clr();
        in0 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) in0 = 1'b0;
            tick();
            if (i == 5) chk("g5_e5_rise", {31'd0, rise0}, 32'h0);
        end
        chk("g5_e6", {30'd0, out0, rise0}, 32'h3);
        tick(12);
        chk("g5_nrise", nr[0], 1);
        chk("g5_nfall", nf[0], 1);

        // 4: bounce to 1, then mirror bounce to 0
        clr();
        for (int k = 0; k < 6; k++) begin
            in0 = (k % 2 == 0);
            tick(2);
        end
        in0 = 1'b1;
        tick(6);
        chk("bnc_pre_rise", nr[0], 0);
        tick();
        chk("bnc_rise", {30'd0, out0, rise0}, 32'h3);
        tick(8);
        chk("bnc_nrise", nr[0], 1);
        chk("bnc_nfall", nf[0], 0);
        clr();
        for (int k = 0; k < 6; k++) begin
            in0 = (k % 2 == 1);
            tick(2);
        end
        in0 = 1'b0;
        tick(6);
        chk("mbnc_pre_fall", nf[0], 0);
        tick();
        chk("mbnc_fall", {30'd0, out0, fall0}, 32'h1);
        tick(8);
        chk("mbnc_nfall", nf[0], 1);
        chk("mbnc_nrise", nr[0], 0);

        // 5: reset mid-WAIT abandons transition, then requalifies
        clr();
        in0 = 1'b1;
        tick(4);
        chk("mw_busy", {31'd0, busy0}, 32'h1);
        rst0 = 1'b1;
        tick();
        chk("mw_rst", {28'd0, out0, busy0, rise0, fall0}, 32'h0);
        rst0 = 1'b0;
        tick(6);
        chk("mw_no_early", nr[0], 0);
        tick();
        chk("mw_rise", {30'd0, out0, rise0}, 32'h3);
        tick(3);
        chk("mw_nrise", nr[0], 1);

        // 6a: N=1
        clr();
        rst1 = 1'b0;
        tick(3);
        in1 = 1'b1;
        tick(2);
        in1 = 1'b0;
        tick();
        chk("n1_e2", {29'd0, out1, busy1, rise1}, 32'b010);
        tick();
        chk("n1_e3", {29'd0, out1, busy1, rise1}, 32'b101);
        tick(6);
        chk("n1_nrise", nr[1], 1);

        // 6b: RESET_LEVEL=1 with in=1
        clr();
        rst2 = 1'b0;
        tick(15);
        chk("rl1_out", {30'd0, out2, busy2}, 32'h2);
        chk("rl1_nfall", nf[2], 0);

        // 6c: CNT_W=4, N=15
        clr();
        rst3 = 1'b0;
        tick(3);
        in3 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i == 16) chk("n15_e16", {29'd0, out3, busy3, rise3}, 32'b010);
        end
        chk("n15_e17", {29'd0, out3, busy3, rise3}, 32'b101);
        tick(20);
        chk("n15_nrise", nr[3], 1);
        chk("n15_out", {30'd0, out3, busy3}, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
